fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_perf_counter.sv | 29 ++
 rtl/fetch_controller.sv | 152 +++++++++++++++
 tb/tb_fetch_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
// Contents: fetch_state_t FSM encoding, NOP filler word, instruction stride and
// counter width. No ports.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,   // one idle cycle after reset
    ST_FETCH,  // issue request at pc
    ST_WAIT,   // request outstanding, memory not yet ready
    ST_DRAIN,  // request outstanding but its response is unwanted (redirected)
    ST_HELD    // response parked in skid buffer while IF/ID is stalled
  } fetch_state_t;

  localparam logic [31:0] NOP        = 32'h00000013;  // addi x0, x0, 0
  localparam logic [31:0] INSN_BYTES = 32'd4;
  localparam int          CNT_W      = 32;

endpackage

// File: rtl/fetch_perf_counter.sv
// rtl/fetch_perf_counter.sv - stall and flush event counters for the fetch stage
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_event       1 = IF/ID held with a valid instruction this cycle
//   flush_event       1 = redirect seen this cycle
//   stall_cycles      free-running count of stall_event cycles (wraps)
//   flush_count       free-running count of flush_event cycles (wraps)
module fetch_perf_counter
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_event,
  input  logic             flush_event,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_event) stall_cycles <= stall_cycles + 1'b1;
      if (flush_event) flush_count  <= flush_count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch FSM with IF/ID register and skid buffer
// Optional feature macro: FETCH_PERF_CNT_EN (adds stall_cycles / flush_count).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   branch_taken, branch_target redirect request and address from EX/MEM
//   stall                      hazard hold for IF/ID
//   imem_ready, imem_rdata     instruction memory response
//   imem_req, imem_addr        instruction memory request
//   if_id_valid/npc/ir         registered IF/ID contents
//   stall_cycles, flush_count  performance counters (FETCH_PERF_CNT_EN only)
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        if_id_valid,
  output logic [31:0] if_id_npc,
  output logic [31:0] if_id_ir
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  req_addr;    // address of the request held across WAIT/DRAIN
  logic         skid_valid;
  logic [31:0]  skid_ir;
  logic [31:0]  skid_npc;
  logic         capture;
  logic         skid_write;
  logic         skid_release;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_next;
  end

  // Next-state logic; a redirect never leaves an accepted request dangling,
  // so an unanswered outstanding request is drained before refetching.
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:  state_next = ST_FETCH;
      ST_FETCH: begin
        if (!branch_taken && !stall && !imem_ready) state_next = ST_WAIT;
        else                                        state_next = ST_FETCH;
      end
      ST_WAIT: begin
        if (branch_taken)    state_next = imem_ready ? ST_FETCH : ST_DRAIN;
        else if (imem_ready) state_next = stall ? ST_HELD : ST_FETCH;
        else                 state_next = ST_WAIT;
      end
      ST_DRAIN: state_next = imem_ready ? ST_FETCH : ST_DRAIN;
      ST_HELD: begin
        if (branch_taken || !stall) state_next = ST_FETCH;
        else                        state_next = ST_HELD;
      end
      default:  state_next = ST_BOOT;
    endcase
  end

  // Output / datapath-strobe logic; redirect suppresses every data movement
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = pc;
    capture      = 1'b0;
    skid_write   = 1'b0;
    skid_release = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = !stall;
        capture  = !stall && imem_ready && !branch_taken;
      end
      ST_WAIT: begin
        imem_req   = 1'b1;
        imem_addr  = req_addr;
        capture    = imem_ready && !stall && !branch_taken;
        skid_write = imem_ready && stall && !branch_taken;
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
      end
      ST_HELD:  skid_release = !stall && !branch_taken;
      default:  ;
    endcase
  end

  // PC, IF/ID register and skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_npc   <= '0;
      if_id_ir    <= NOP;
      skid_valid  <= 1'b0;
      skid_ir     <= NOP;
      skid_npc    <= '0;
    end else begin
      if (state == ST_FETCH) req_addr <= pc;
      if (branch_taken) begin
        pc          <= branch_target;
        if_id_valid <= 1'b0;
        if_id_npc   <= '0;
        if_id_ir    <= NOP;
        skid_valid  <= 1'b0;
      end else if (capture) begin
        if_id_ir    <= imem_rdata;
        if_id_npc   <= imem_addr + INSN_BYTES;
        if_id_valid <= 1'b1;
        pc          <= pc + INSN_BYTES;
      end else if (skid_write) begin
        // pc advances now so fetch resumes past the parked instruction
        skid_ir     <= imem_rdata;
        skid_npc    <= imem_addr + INSN_BYTES;
        skid_valid  <= 1'b1;
        pc          <= pc + INSN_BYTES;
      end else if (skid_release) begin
        if_id_ir    <= skid_ir;
        if_id_npc   <= skid_npc;
        if_id_valid <= skid_valid;
        skid_valid  <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_event  (stall && if_id_valid),
    .flush_event  (branch_taken),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed table-driven bench for fetch_controller
module tb_fetch_controller;

  localparam logic [31:0] NOPW = 32'h00000013;
  localparam logic [31:0] IA   = 32'h00500093;
  localparam logic [31:0] IB   = 32'h00100113;
  localparam logic [31:0] IC   = 32'h00208193;
  localparam logic [31:0] ID   = 32'h00318213;
  localparam logic [31:0] IE   = 32'h00420293;
  localparam logic [31:0] IF   = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_id_valid;
  logic [31:0] if_id_npc;
  logic [31:0] if_id_ir;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  fetch_controller #(.RESET_PC(32'h00000000)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .if_id_valid   (if_id_valid),
    .if_id_npc     (if_id_npc),
    .if_id_ir      (if_id_ir)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        rdy;
    logic [31:0] rdata;
    logic        req;    // expected before the edge
    logic [31:0] addr;   // expected before the edge
    logic        v;      // expected after the edge
    logic [31:0] npc;
    logic [31:0] ir;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  logic prev_v = 1'b0;

  task automatic add(input logic br, input logic [31:0] tgt, input logic st,
                     input logic rdy, input logic [31:0] rdata, input logic req,
                     input logic [31:0] addr, input logic v, input logic [31:0] npc,
                     input logic [31:0] ir);
    vec_t t;
    t.br = br; t.tgt = tgt; t.stall = st; t.rdy = rdy; t.rdata = rdata;
    t.req = req; t.addr = addr; t.v = v; t.npc = npc; t.ir = ir;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic st,
                       input logic rdy, input logic [31:0] rdata);
    branch_taken = br; branch_target = tgt; stall = st;
    imem_ready = rdy; imem_rdata = rdata;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   0, {31'b0, imem_req},    32'd0);
    chk("rst_valid", 0, {31'b0, if_id_valid}, 32'd0);
    chk("rst_ir",    0, if_id_ir,             NOPW);
    chk("rst_npc",   0, if_id_npc,            32'd0);
    rst = 1'b0;

    //   br  tgt           st  rdy rdata  req addr          v   npc           ir
    // reset release, back-to-back fetch
    add(0, 32'h0,        0, 1, IA,    0, 32'h0,         0, 32'h0,         NOPW);
    add(0, 32'h0,        0, 1, IA,    1, 32'h0,         1, 32'h4,         IA);
    add(0, 32'h0,        0, 1, IB,    1, 32'h4,         1, 32'h8,         IB);
    // three-cycle memory delay at pc=8
    add(0, 32'h0,        0, 0, IF,    1, 32'h8,         1, 32'h8,         IB);
    add(0, 32'h0,        0, 0, IF,    1, 32'h8,         1, 32'h8,         IB);
    add(0, 32'h0,        0, 0, IF,    1, 32'h8,         1, 32'h8,         IB);
    add(0, 32'h0,        0, 1, IC,    1, 32'h8,         1, 32'hC,         IC);
    // stall arrives as WAIT completes -> skid, HELD, release
    add(0, 32'h0,        0, 0, IF,    1, 32'hC,         1, 32'hC,         IC);
    add(0, 32'h0,        1, 1, ID,    1, 32'hC,         1, 32'hC,         IC);
    add(0, 32'h0,        1, 1, IE,    0, 32'h10,        1, 32'hC,         IC);
    add(0, 32'h0,        0, 1, IE,    0, 32'h10,        1, 32'h10,        ID);
    add(0, 32'h0,        0, 1, IE,    1, 32'h10,        1, 32'h14,        IE);
    // redirect during WAIT, late response dropped in DRAIN
    add(0, 32'h0,        0, 0, IF,    1, 32'h14,        1, 32'h14,        IE);
    add(1, 32'h100,      0, 0, IF,    1, 32'h14,        0, 32'h0,         NOPW);
    add(0, 32'h0,        0, 0, IF,    1, 32'h14,        0, 32'h0,         NOPW);
    add(0, 32'h0,        0, 1, IF,    1, 32'h14,        0, 32'h0,         NOPW);
    add(0, 32'h0,        0, 1, IA,    1, 32'h100,       1, 32'h104,       IA);
    // redirect and stall together in FETCH, then stall hold
    add(1, 32'h200,      1, 1, IB,    0, 32'h104,       0, 32'h0,         NOPW);
    add(0, 32'h0,        0, 1, IC,    1, 32'h200,       1, 32'h204,       IC);
    add(0, 32'h0,        1, 1, ID,    0, 32'h204,       1, 32'h204,       IC);
    add(0, 32'h0,        0, 1, ID,    1, 32'h204,       1, 32'h208,       ID);

    #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].br, vq[i].tgt, vq[i].stall, vq[i].rdy, vq[i].rdata);
      @(negedge clk);
      if (vq[i].stall && prev_v) exp_stall++;
      if (vq[i].br) exp_flush++;
      chk("req",  i, {31'b0, imem_req}, {31'b0, vq[i].req});
      chk("addr", i, imem_addr,         vq[i].addr);
      @(posedge clk);
      #1;
      chk("valid", i, {31'b0, if_id_valid}, {31'b0, vq[i].v});
      chk("npc",   i, if_id_npc,            vq[i].npc);
      chk("ir",    i, if_id_ir,             vq[i].ir);
      prev_v = vq[i].v;
    end

`ifdef FETCH_PERF_CNT_EN
    chk("stall_cycles", 0, stall_cycles, exp_stall);
    chk("flush_count",  0, flush_count,  exp_flush);
`endif

    // pc wrap-around: 32'hFFFFFFFC + 4 = 0
    drive(1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, IB);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, IA);
    @(negedge clk);
    chk("wrap_addr", 0, imem_addr, 32'hFFFFFFFC);
    @(posedge clk); #1;
    chk("wrap_npc",   0, if_id_npc,            32'h0);
    chk("wrap_valid", 0, {31'b0, if_id_valid}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, IA);
    @(negedge clk);
    chk("wrap_pc", 0, imem_addr, 32'h0);
    @(posedge clk); #1;

    // reset asserted mid-WAIT
    drive(1'b1, 32'h300, 1'b0, 1'b0, IF);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, IF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_req",  0, {31'b0, imem_req}, 32'd1);
    chk("wait_addr", 0, imem_addr,         32'h300);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_req",   0, {31'b0, imem_req},    32'd0);
    chk("midrst_pc",    0, imem_addr,            32'h0);
    chk("midrst_valid", 0, {31'b0, if_id_valid}, 32'd0);
    chk("midrst_ir",    0, if_id_ir,             NOPW);
    chk("midrst_npc",   0, if_id_npc,            32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_stall_cycles", 0, stall_cycles, 32'd0);
    chk("midrst_flush_count",  0, flush_count,  32'd0);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b1, IB);
    @(negedge clk);
    chk("boot_req", 0, {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("refetch_req",  0, {31'b0, imem_req}, 32'd1);
    chk("refetch_addr", 0, imem_addr,         32'h0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
